// File: rtl/servile_wb_arbiter.sv
// servile_wb_arbiter: N-port Wishbone arbiter (fixed/round-robin), optional watchdog via SERVILE_ARB_TIMEOUT_EN
module servile_wb_arbiter #(
   parameter int NUM_PORTS      = 2,
   parameter bit ROUND_ROBIN    = 1'b0,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic [NUM_PORTS*32-1:0] i_wb_m_adr,
   input  logic [NUM_PORTS*32-1:0] i_wb_m_dat,
   input  logic [NUM_PORTS*4-1:0]  i_wb_m_sel,
   input  logic [NUM_PORTS-1:0]    i_wb_m_we,
   input  logic [NUM_PORTS-1:0]    i_wb_m_stb,
   output logic [31:0]             o_wb_m_rdt,
   output logic [NUM_PORTS-1:0]    o_wb_m_ack,
   output logic [31:0]             o_wb_mem_adr,
   output logic [31:0]             o_wb_mem_dat,
   output logic [3:0]              o_wb_mem_sel,
   output logic                    o_wb_mem_we,
   output logic                    o_wb_mem_stb,
   input  logic [31:0]             i_wb_mem_rdt,
   input  logic                    i_wb_mem_ack,
   output logic [NUM_PORTS-1:0]    o_grant,
   output logic                    o_timeout
);
   localparam int IW = $clog2(NUM_PORTS);
   typedef enum logic {IDLE, BUSY} state_t;
   state_t state_q, state_d;
   logic [NUM_PORTS-1:0] grant_q, grant_d;
   logic [IW-1:0] last_q, last_d, pick, sel_idx;
   logic found, busy, to_hit, done;
   int j;
   assign busy = state_q == BUSY;
   assign sel_idx = busy ? last_q : '0;
`ifdef SERVILE_ARB_TIMEOUT_EN
   logic [15:0] cnt_q, cnt_d;
   assign cnt_d = busy ? cnt_q + 16'd1 : 16'd0;
   // BUSY-cycle counter, zero on the first BUSY cycle of each grant
   always_ff @(posedge i_clk) begin
      cnt_q <= i_rst ? 16'd0 : cnt_d;
   end
   assign to_hit = busy && cnt_q == 16'(TIMEOUT_CYCLES - 1);
`else
   assign to_hit = TIMEOUT_CYCLES < 0;
`endif
   assign done = busy && (i_wb_mem_ack || to_hit);
   assign o_timeout = busy && to_hit && !i_wb_mem_ack;
   assign o_grant = grant_q;
   assign o_wb_mem_stb = busy;
   assign o_wb_mem_adr = i_wb_m_adr[sel_idx*32 +: 32];
   assign o_wb_mem_dat = i_wb_m_dat[sel_idx*32 +: 32];
   assign o_wb_mem_sel = i_wb_m_sel[sel_idx*4 +: 4];
   assign o_wb_mem_we = i_wb_m_we[sel_idx];
   assign o_wb_m_ack = done ? grant_q : '0;
   assign o_wb_m_rdt = o_timeout ? 32'h0 : i_wb_mem_rdt;
   // winner search: lowest index, or rotating from the port after the last grant
   always_comb begin
      pick = '0;
      found = 1'b0;
      j = 0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         j = ROUND_ROBIN ? (int'(last_q) + 1 + i) % NUM_PORTS : i;
         if (!found && i_wb_m_stb[j]) begin
            pick = IW'(j);
            found = 1'b1;
         end
      end
   end
   // IDLE/BUSY next state, grant and last-granted bookkeeping
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d = last_q;
      if (!busy && found) begin
         state_d = BUSY;
         grant_d = NUM_PORTS'(1) << pick;
         last_d = pick;
      end else if (done) begin
         state_d = IDLE;
         grant_d = '0;
      end
   end
   // state registers; reset aborts any transaction in flight
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         last_q <= IW'(NUM_PORTS - 1);
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q <= last_d;
      end
   end
endmodule

// File: tb/tb_servile_wb_arbiter.sv
// tb_servile_wb_arbiter: directed checks on 2-port fixed, 4-port fixed and 4-port round-robin arbiters
module tb_servile_wb_arbiter;
   logic clk = 1'b0;
   logic rst;
   logic [127:0] adr, dat;
   logic [15:0] sel;
   logic [3:0] we;
   logic [1:0] stb2;
   logic [3:0] stb4, stbr;
   logic [31:0] mem_rdt;
   logic mem_ack;
   logic [31:0] rdt2, madr2, mdat2, rdt4, madr4, mdat4, rdtr, madrr, mdatr;
   logic [3:0] msel2, msel4, mselr;
   logic mwe2, mstb2, to2, mwe4, mstb4, to4, mwer, mstbr, tor;
   logic [1:0] ack2, grant2;
   logic [3:0] ack4, grant4, ackr, grantr;
   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   servile_wb_arbiter #(.NUM_PORTS(2), .ROUND_ROBIN(1'b0), .TIMEOUT_CYCLES(4)) d2 (
      .i_clk(clk), .i_rst(rst), .i_wb_m_adr(adr[63:0]), .i_wb_m_dat(dat[63:0]),
      .i_wb_m_sel(sel[7:0]), .i_wb_m_we(we[1:0]), .i_wb_m_stb(stb2),
      .o_wb_m_rdt(rdt2), .o_wb_m_ack(ack2), .o_wb_mem_adr(madr2), .o_wb_mem_dat(mdat2),
      .o_wb_mem_sel(msel2), .o_wb_mem_we(mwe2), .o_wb_mem_stb(mstb2),
      .i_wb_mem_rdt(mem_rdt), .i_wb_mem_ack(mem_ack), .o_grant(grant2), .o_timeout(to2));

   servile_wb_arbiter #(.NUM_PORTS(4), .ROUND_ROBIN(1'b0), .TIMEOUT_CYCLES(4)) d4 (
      .i_clk(clk), .i_rst(rst), .i_wb_m_adr(adr), .i_wb_m_dat(dat),
      .i_wb_m_sel(sel), .i_wb_m_we(we), .i_wb_m_stb(stb4),
      .o_wb_m_rdt(rdt4), .o_wb_m_ack(ack4), .o_wb_mem_adr(madr4), .o_wb_mem_dat(mdat4),
      .o_wb_mem_sel(msel4), .o_wb_mem_we(mwe4), .o_wb_mem_stb(mstb4),
      .i_wb_mem_rdt(mem_rdt), .i_wb_mem_ack(mem_ack), .o_grant(grant4), .o_timeout(to4));

   servile_wb_arbiter #(.NUM_PORTS(4), .ROUND_ROBIN(1'b1), .TIMEOUT_CYCLES(4)) dr (
      .i_clk(clk), .i_rst(rst), .i_wb_m_adr(adr), .i_wb_m_dat(dat),
      .i_wb_m_sel(sel), .i_wb_m_we(we), .i_wb_m_stb(stbr),
      .o_wb_m_rdt(rdtr), .o_wb_m_ack(ackr), .o_wb_mem_adr(madrr), .o_wb_mem_dat(mdatr),
      .o_wb_mem_sel(mselr), .o_wb_mem_we(mwer), .o_wb_mem_stb(mstbr),
      .i_wb_mem_rdt(mem_rdt), .i_wb_mem_ack(mem_ack), .o_grant(grantr), .o_timeout(tor));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1;
      stb2 = '0;
      stb4 = '0;
      stbr = '0;
      mem_ack = 1'b0;
      mem_rdt = 32'h0;
      for (int k = 0; k < 4; k++) begin
         adr[k*32 +: 32] = 32'h100 * k;
         dat[k*32 +: 32] = 32'hD0 + k;
         sel[k*4 +: 4] = 4'h1 << k;
      end
      we = 4'b0100;
      tick();
      tick();
      rst = 1'b0;
      #1;
      chk("rst_grant2", grant2, 0);
      chk("rst_grant4", grant4, 0);
      chk("rst_grantr", grantr, 0);
      chk("rst_stb", {mstb2, mstb4, mstbr}, 0);
      chk("rst_ack", {ack2, ack4, ackr}, 0);
      chk("rst_to", {to2, to4, tor}, 0);
      chk("idle_adr_port0", madr2, 32'h0);

      stb2 = 2'b10;
      #1;
      chk("t1_stb_pre", mstb2, 0);
      tick();
      chk("t1_grant", grant2, 2'b10);
      chk("t1_mem_stb", mstb2, 1);
      chk("t1_mem_adr", madr2, 32'h100);
      chk("t1_mem_we", mwe2, 0);
      chk("t1_mem_sel", msel2, 4'h2);
      chk("t1_no_ack1", ack2, 0);
      tick();
      chk("t1_no_ack2", ack2, 0);
      tick();
      mem_rdt = 32'hCAFEF00D;
      mem_ack = 1'b1;
      #1;
      chk("t1_ack", ack2, 2'b10);
      chk("t1_rdt", rdt2, 32'hCAFEF00D);
      tick();
      mem_ack = 1'b0;
      stb2 = '0;
      #1;
      chk("t1_grant_clr", grant2, 0);
      chk("t1_stb_clr", mstb2, 0);
      chk("t1_ack_clr", ack2, 0);

      stb4 = 4'b1110;
      tick();
      for (int k = 1; k < 4; k++) begin
         chk($sformatf("t2_grant%0d", k), grant4, 32'h1 << k);
         chk($sformatf("t2_adr%0d", k), madr4, 32'h100 * k);
         chk($sformatf("t2_we%0d", k), mwe4, k == 2 ? 1 : 0);
         mem_ack = 1'b1;
         #1;
         chk($sformatf("t2_ack%0d", k), ack4, 32'h1 << k);
         tick();
         mem_ack = 1'b0;
         stb4[k] = 1'b0;
         #1;
         chk($sformatf("t2_gap%0d", k), grant4, 0);
         tick();
      end
      chk("t2_idle_end", grant4, 0);

      stbr = 4'b1001;
      tick();
      for (int n = 0; n < 4; n++) begin
         chk($sformatf("t3_grant%0d", n), grantr, n % 2 ? 4'b1000 : 4'b0001);
         mem_ack = 1'b1;
         #1;
         chk($sformatf("t3_ack%0d", n), ackr, n % 2 ? 4'b1000 : 4'b0001);
         tick();
         mem_ack = 1'b0;
         if (n == 3) stbr = '0;
         #1;
         chk($sformatf("t3_gap%0d", n), grantr, 0);
         tick();
      end
      chk("t3_idle_end", grantr, 0);

      stb2 = 2'b01;
      tick();
      chk("t4_grant", grant2, 2'b01);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      stb2 = '0;
      mem_ack = 1'b1;
      #1;
      chk("t4_no_ack", ack2, 0);
      chk("t4_grant_rst", grant2, 0);
      chk("t4_stb_rst", mstb2, 0);
      chk("t4_to_rst", to2, 0);
      tick();
      mem_ack = 1'b0;
      #1;
      chk("t4_still_idle", grant2, 0);

      mem_rdt = 32'hDEADBEEF;
      stb4 = 4'b0100;
      tick();
      chk("t5_grant", grant4, 4'b0100);
      for (int c = 1; c < 4; c++) begin
         chk($sformatf("t5_no_ack_b%0d", c), ack4, 0);
         chk($sformatf("t5_no_to_b%0d", c), to4, 0);
         tick();
      end
`ifdef SERVILE_ARB_TIMEOUT_EN
      chk("t5_to_ack", ack4, 4'b0100);
      chk("t5_to_rdt", rdt4, 32'h0);
      chk("t5_to_pulse", to4, 1);
      tick();
      stb4 = '0;
      #1;
      chk("t5_to_low", to4, 0);
      chk("t5_grant_clr", grant4, 0);
      mem_ack = 1'b1;
      #1;
      chk("t5_late_ack", ack4, 0);
      tick();
      mem_ack = 1'b0;
      #1;
      chk("t5_idle", grant4, 0);
`else
      chk("t5_wait_ack", ack4, 0);
      chk("t5_wait_to", to4, 0);
      chk("t5_wait_grant", grant4, 4'b0100);
      mem_ack = 1'b1;
      #1;
      chk("t5_ack", ack4, 4'b0100);
      chk("t5_rdt", rdt4, 32'hDEADBEEF);
      tick();
      mem_ack = 1'b0;
      stb4 = '0;
      #1;
      chk("t5_idle", grant4, 0);
`endif

      mem_ack = 1'b1;
      #1;
      chk("t6_no_ack", ack2, 0);
      tick();
      chk("t6_grant", grant2, 0);
      chk("t6_stb", mstb2, 0);
      mem_ack = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
